// File: rtl/wid_lane_serializer_pkg.sv
// Shared types and helpers for the wide-word lane serializer.
// Index/count helpers take the lane count as an argument so lane engines of any width can share them.
package wid_lane_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } wid_lane_state_e;

    function automatic int count_clamp(input int n, input int num_lanes);
        return (n == 0 || n > num_lanes) ? num_lanes : n;
    endfunction

    function automatic int idx_step(input int idx, input logic dec, input int num_lanes);
        if (dec)
            return (idx == 0) ? num_lanes - 1 : idx - 1;
        return (idx == num_lanes - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wid_lane_serializer_if.sv
// Word-in / lane-out handshake bundle for the lane serializer.
interface wid_lane_serializer_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
);
    localparam int NUM_LANES = DATA_W / LANE_W;
    localparam int IDX_W     = $clog2(NUM_LANES);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  in_first_lane;
    logic [IDX_W:0]    in_num_lanes;
    logic              in_msb_first;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_data;
    logic [IDX_W-1:0]  out_lane_idx;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_first_lane, in_num_lanes, in_msb_first, out_ready,
        input  in_ready, out_valid, out_data, out_lane_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_first_lane, in_num_lanes, in_msb_first, out_ready,
        output in_ready, out_valid, out_data, out_lane_idx, out_last
    );
endinterface

// File: rtl/wid_lane_serializer_mux.sv
// Combinational lane selector: picks lane i_idx out of a wide word.
module wid_lane_mux #(
    parameter int  DATA_W    = 32,
    parameter int  LANE_W    = 8,
    localparam int NUM_LANES = DATA_W / LANE_W,
    localparam int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [LANE_W-1:0] o_lane
);
    assign o_lane = i_word[LANE_W*i_idx +: LANE_W];
endmodule

// File: rtl/wid_lane_serializer.sv
// Wide-word to lane serializer with programmable start lane, lane count and direction.
// Lane outputs come from held registers only; in_ready alone looks at out_ready.
module wid_lane_serializer
    import wid_lane_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    wid_lane_serializer_if.slave bus,
    output logic                 busy
);
    localparam int NUM_LANES = DATA_W / LANE_W;
    localparam int IDX_W     = $clog2(NUM_LANES);

    if (DATA_W % LANE_W != 0) begin : g_bad_ratio
        $error("DATA_W must be a multiple of LANE_W");
    end
    if (NUM_LANES < 2) begin : g_too_few_lanes
        $error("NUM_LANES must be at least 2");
    end

    wid_lane_state_e   r_state;
    wid_lane_state_e   w_state_nxt;
    logic [DATA_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W:0]    r_remaining;
    logic              r_dir;

    logic w_last;
    logic w_out_fire;
    logic w_accept;

    assign w_last     = (r_remaining == (IDX_W+1)'(1));
    assign w_out_fire = bus.out_valid && bus.out_ready;
    assign w_accept   = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = SHIFT;
            SHIFT: if (w_out_fire && w_last) w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.in_ready  = 1'b0;
        busy          = 1'b0;
        case (r_state)
            IDLE: bus.in_ready = 1'b1;
            SHIFT: begin
                bus.out_valid = 1'b1;
                bus.out_last  = w_last;
                bus.in_ready  = bus.out_ready && w_last;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    // A new word takes priority so a last-lane transfer can reload without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
        end else if (w_accept) begin
            r_word      <= bus.in_data;
            r_idx       <= bus.in_first_lane;
            r_remaining <= (IDX_W+1)'(count_clamp(int'(bus.in_num_lanes), NUM_LANES));
            r_dir       <= bus.in_msb_first;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_remaining <= '0;
            end else begin
                r_idx       <= IDX_W'(idx_step(int'(r_idx), r_dir, NUM_LANES));
                r_remaining <= r_remaining - (IDX_W+1)'(1);
            end
        end
    end

    assign bus.out_lane_idx = r_idx;

    wid_lane_mux #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_mux (
        .i_word (r_word),
        .i_idx  (r_idx),
        .o_lane (bus.out_data)
    );

endmodule

// File: tb/tb_wid_lane_serializer.sv
// Directed self-checking bench for wid_lane_serializer (DATA_W=32, LANE_W=8).
module tb_wid_lane_serializer;
    import wid_lane_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    wid_lane_serializer_if #(.DATA_W(32), .LANE_W(8)) bus ();

    wid_lane_serializer #(.DATA_W(32), .LANE_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        checks++; if (bus.out_lane_idx !== 2'd0) begin errors++; $display("FAIL reset_lane_idx: got %0d want 0", bus.out_lane_idx); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    endtask

    // exp_d packs expected lanes LSB-first (byte k = k-th lane); exp_i packs 2-bit indices likewise.
    task automatic test_pattern(input string name, input logic [31:0] data, input logic [1:0] first,
                                input logic [2:0] num, input logic msb, input int n,
                                input logic [31:0] exp_d, input logic [7:0] exp_i);
        @(negedge clk);
        bus.in_data       = data;
        bus.in_first_lane = first;
        bus.in_num_lanes  = num;
        bus.in_msb_first  = msb;
        bus.in_valid      = 1'b1;
        bus.out_ready     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~data;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i*8 +: 8] ||
                bus.out_lane_idx !== exp_i[i*2 +: 2] || bus.out_last !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s lane%0d: valid=%b data=%h idx=%0d last=%b, want valid=1 data=%h idx=%0d last=%b",
                         name, i, bus.out_valid, bus.out_data, bus.out_lane_idx, bus.out_last,
                         exp_d[i*8 +: 8], exp_i[i*2 +: 2], (i == n - 1));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_after: valid=%b busy=%b in_ready=%b, want 0 0 1",
                     name, bus.out_valid, busy, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_d = 64'h44332211_DDCCBBAA;
        @(negedge clk);
        bus.in_data       = 32'hDDCCBBAA;
        bus.in_first_lane = 2'd0;
        bus.in_num_lanes  = 3'd4;
        bus.in_msb_first  = 1'b0;
        bus.in_valid      = 1'b1;
        bus.out_ready     = 1'b1;
        @(posedge clk); #1;
        bus.in_data = 32'h44332211;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i*8 +: 8] ||
                bus.in_ready !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b lane%0d: valid=%b data=%h in_ready=%b, want valid=1 data=%h in_ready=%b",
                         i, bus.out_valid, bus.out_data, bus.in_ready, exp_d[i*8 +: 8], (i == 3 || i == 7));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_d = 32'hD4A1B2C3;
        logic [7:0]  exp_i = 8'h39;
        logic [15:0] pat   = 16'hFF62;
        int got = 0;
        int c   = 0;
        @(negedge clk);
        bus.in_data       = 32'hA1B2C3D4;
        bus.in_first_lane = 2'd1;
        bus.in_num_lanes  = 3'd4;
        bus.in_msb_first  = 1'b0;
        bus.in_valid      = 1'b1;
        bus.out_ready     = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        while (got < 4 && c < 40) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[got*8 +: 8] ||
                bus.out_lane_idx !== exp_i[got*2 +: 2] || bus.out_last !== (got == 3)) begin
                errors++;
                $display("FAIL stall cyc%0d lane%0d: valid=%b data=%h idx=%0d last=%b, want valid=1 data=%h idx=%0d last=%b",
                         c, got, bus.out_valid, bus.out_data, bus.out_lane_idx, bus.out_last,
                         exp_d[got*8 +: 8], exp_i[got*2 +: 2], (got == 3));
            end
            bus.out_ready = pat[c % 16];
            if (bus.out_ready && bus.out_valid) got++;
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL stall_timeout: got %0d lanes want 4", got); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra_lane: out_valid=%b want 0", bus.out_valid); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.in_data       = 32'hDDCCBBAA;
        bus.in_first_lane = 2'd0;
        bus.in_num_lanes  = 3'd4;
        bus.in_msb_first  = 1'b0;
        bus.in_valid      = 1'b1;
        bus.out_ready     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_data !== 8'hCC) begin errors++; $display("FAIL midrst_pre: data=%h want cc", bus.out_data); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_data !== 8'h00 || bus.out_lane_idx !== 2'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post: valid=%b busy=%b in_ready=%b data=%h idx=%0d last=%b, want 0 0 1 00 0 0",
                     bus.out_valid, busy, bus.in_ready, bus.out_data, bus.out_lane_idx, bus.out_last);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_leak: out_valid=%b want 0", bus.out_valid); end
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_first_lane = '0;
        bus.in_num_lanes  = '0;
        bus.in_msb_first  = 1'b0;
        bus.out_ready     = 1'b0;
        test_reset();
        test_pattern("basic",  32'hDDCCBBAA, 2'd0, 3'd4, 1'b0, 4, 32'hDDCCBBAA, 8'hE4);
        test_pattern("wrap",   32'hDDCCBBAA, 2'd2, 3'd3, 1'b0, 3, 32'h00AADDCC, 8'h0E);
        test_pattern("msb",    32'hDDCCBBAA, 2'd1, 3'd3, 1'b1, 3, 32'h00DDAABB, 8'h31);
        test_pattern("num0",   32'hDDCCBBAA, 2'd0, 3'd0, 1'b0, 4, 32'hDDCCBBAA, 8'hE4);
        test_pattern("num7",   32'h87654321, 2'd3, 3'd7, 1'b1, 4, 32'h21436587, 8'h1B);
        test_pattern("num1",   32'hDDCCBBAA, 2'd2, 3'd1, 1'b0, 1, 32'h000000CC, 8'h02);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_pattern("postrst", 32'h55667788, 2'd0, 3'd2, 1'b0, 2, 32'h00007788, 8'h04);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
